// File: rtl/led_pattern_gen.sv
// led_pattern_gen: prescaled step timer driving rotate, ping-pong, bar-fill and blink LED patterns.
module led_pattern_gen #(
  parameter int LED_N      = 4,
  parameter int CNT_W      = 26,
  parameter int TICK_MAX   = 24_999_999,
  parameter int ACTIVE_LOW = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [3:0]       step_div,
  output logic [LED_N-1:0] led,
  output logic             step_pulse,
  output logic             dir
);
  localparam int PW = $clog2(LED_N + 1);
  localparam logic [PW-1:0] TOP  = PW'(LED_N - 1);
  localparam logic [PW-1:0] FULL = PW'(LED_N);
  logic [CNT_W-1:0] cnt;
  logic [3:0]       div;
  logic [PW-1:0]    pos, pos_n, up, dn;
  logic [1:0]       mode_q;
  logic             tick, step, mchg, dir_n;
  // Physical LED drive for a pattern position; bar-fill needs one extra bit so pos==N lights all
  function automatic logic [LED_N-1:0] pat(input logic [1:0] m, input logic [PW-1:0] p);
    logic [LED_N:0]   one;
    logic [LED_N-1:0] r;
    one = (LED_N + 1)'(1) << p;
    r = m == 2'd3 ? {LED_N{~p[0]}} : m == 2'd2 ? LED_N'(one - 1'b1) : one[LED_N-1:0];
    return ACTIVE_LOW != 0 ? ~r : r;
  endfunction
  assign tick = en && cnt == CNT_W'(TICK_MAX);
  assign step = tick && div >= step_div;
  assign mchg = en && mode != mode_q;
  assign up   = pos + 1'b1;
  assign dn   = pos - 1'b1;
  always_comb begin
    pos_n = mode_q == 2'd3 ? pos ^ PW'(1) :
            mode_q == 2'd2 ? (pos == FULL ? '0 : up) :
            mode_q == 2'd1 ? (dir ? dn : up) :
            (pos == TOP ? '0 : up);
    dir_n = mode_q == 2'd1 ? (dir ? dn != '0 : up == TOP) : dir;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      div        <= '0;
      pos        <= '0;
      dir        <= 1'b0;
      mode_q     <= mode;
      led        <= pat(mode, '0);
      step_pulse <= 1'b0;
    end else begin
      step_pulse <= 1'b0;
      if (mchg) begin
        mode_q <= mode;
        pos    <= '0;
        dir    <= 1'b0;
        cnt    <= '0;
        div    <= '0;
        led    <= pat(mode, '0);
      end else if (en) begin
        cnt <= tick ? '0 : cnt + 1'b1;
        if (tick) div <= step ? '0 : div + 1'b1;
        if (step) begin
          pos        <= pos_n;
          dir        <= dir_n;
          led        <= pat(mode_q, pos_n);
          step_pulse <= 1'b1;
        end
      end
    end
  end
endmodule
